delay_seq_ctrl: RTL
===================

Name: delay_seq_ctrl

Overview:
- Sequencer for the 256-tap complex delay line in the CP-correlation front end.
- The delay line shifts every clock and has no valid or enable, so this block supplies three things:
  - frame start/clear sequencing: a one-cycle synchronous clear pulse to the delay line;
  - input acceptance (`in_ready`);
  - a valid-tracking shadow pipeline, which qualifies the 1-cycle and N-cycle taps for the downstream correlator.
- After the last input sample it drains the line so every accepted sample appears at the N tap.

Parameters:
- N, 256, delay-line depth; must match the datapath.
- LW, 16, width of frame_len and sample_idx.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset; all state clears while rst=0.
- start  in  1  one-cycle frame start request; ignored unless in IDLE.
- frame_len  in  LW  samples in the frame; sampled only in the cycle start is accepted.
- abort  in  1  cancels the frame from any non-IDLE state.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  high in RUN only; a sample is accepted when in_valid&in_ready.
- dl_clr  out  1  active-high synchronous clear to the delay line.
- d1_valid  out  1  qualifies the 1-cycle delayed tap.
- dN_valid  out  1  qualifies the N-cycle delayed tap.
- pair_valid  out  1  d1_valid & dN_valid.
- sample_idx  out  LW  count of samples accepted in the current frame.
- busy  out  1  high in CLEAR/RUN/DRAIN.
- done  out  1  one-cycle pulse at normal frame completion.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE;
  - all outputs 0;
  - valid pipe cleared;
  - counters 0.
- Valid pipe: an N+1-bit shift register advancing every clock.
  - Bit 0 is loaded with `acc = in_valid & in_ready`.
  - d1_valid = bit 0, so it goes high exactly 1 cycle after acceptance.
  - dN_valid = bit N, so it goes high exactly N+1 cycles after acceptance. This matches the datapath tap latencies.
- States:
  - IDLE: in_ready=0, dl_clr=0. On start, latch frame_len into len_r and go to CLEAR.
  - CLEAR (exactly 1 cycle):
    - dl_clr=1;
    - valid pipe and sample_idx cleared;
    - if len_r==0, go to IDLE with done=1 in the next cycle; otherwise go to RUN.
  - RUN:
    - in_ready=1;
    - each acc increments sample_idx;
    - in_valid=0 inserts a bubble (a 0 shifts into the valid pipe); this is not an error;
    - when acc is asserted and sample_idx==len_r-1, go to DRAIN, so in_ready=0 from the next cycle;
    - load drain_cnt=N.
  - DRAIN:
    - in_ready=0;
    - drain_cnt decrements each cycle;
    - at drain_cnt==0, go to IDLE.
    - Timing: last sample accepted at cycle t gives dN_valid at t+N+1; done=1 and busy=0 at t+N+2.
- done is registered, high for one cycle only.
- sample_idx holds its final value in IDLE until the next CLEAR.
- abort in CLEAR/RUN/DRAIN:
  - next cycle: state=IDLE, dl_clr=1 for that one cycle;
  - valid pipe cleared, so d1/dN/pair_valid drop to 0 the cycle after abort;
  - done is not asserted.
  - abort in IDLE has no effect. abort has priority over start and over all state transitions in the same cycle.
- start while busy: ignored; len_r is unchanged.
- start arriving in the same cycle as done: accepted; CLEAR follows immediately.
- sample_idx saturates at len_r; no wrap is possible because RUN exits at len_r.
- dl_clr is never asserted in RUN or DRAIN except via abort.

Test Plan:
- Reset mid-frame: assert rst=0 during RUN with sample_idx=37 -> all outputs 0 immediately; IDLE after release; no done.
- Basic frame: start with frame_len=300, in_valid held 1 -> dl_clr pulse 1 cycle after start; first d1_valid at acceptance+1; first dN_valid at first acceptance+257; 44 pair_valid cycles overlap... pair_valid high for 300-256=44 cycles; done at last accept+258; sample_idx=300.
- Bubbles: frame_len=10, in_valid pattern 1,0,1,1,0,... -> d1_valid/dN_valid replicate the pattern delayed 1 and 257 cycles; sample_idx=10; DRAIN starts only after the 10th accept.
- frame_len=0 -> CLEAR then IDLE; done one cycle after CLEAR; no valids; in_ready never 1.
- Abort plus same-cycle start: abort during DRAIN with drain_cnt=100 -> IDLE next cycle with dl_clr=1; dN_valid low thereafter; no done. A start asserted in the same cycle as abort is ignored.
- Back-to-back frames: start asserted in the done cycle with frame_len=5 -> CLEAR immediately; no valid from the previous frame leaks (dN_valid=0 until new acceptance+257).

Source files
------------

// File: rtl/delay_seq_ctrl.sv
// Frame sequencer for the CP-correlation delay line: clear pulse, input
// acceptance, drain timing and a valid shadow pipe for the 1- and N-cycle taps.
module delay_seq_ctrl #(
  parameter int N  = 256,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] frame_len,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          dl_clr,
  output logic          d1_valid,
  output logic          dN_valid,
  output logic          pair_valid,
  output logic [LW-1:0] sample_idx,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] len_r;
  logic [CW-1:0] drain_cnt;
  logic [N:0]    vld_p;
  logic          acc;
  logic          last_acc;
  logic          start_go;
  logic          abort_go;
  logic          done_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start_go  = 1'b0;
    abort_go  = 1'b0;
    done_nxt  = 1'b0;
    acc       = 1'b0;
    last_acc  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_go  = 1'b1;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (len_r == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        acc      = in_valid;
        last_acc = in_valid && (sample_idx == len_r - LW'(1));
        if (last_acc) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every transition, including a completion in the same cycle
    if (abort && (state != IDLE)) begin
      abort_go  = 1'b1;
      state_nxt = IDLE;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_clr     <= 1'b0;
      done       <= 1'b0;
      len_r      <= '0;
      sample_idx <= '0;
      drain_cnt  <= '0;
    end else begin
      dl_clr <= start_go | abort_go;
      done   <= done_nxt;
      if (start_go) begin
        len_r      <= frame_len;
        sample_idx <= '0;
      end else if (acc && !abort_go) begin
        sample_idx <= sample_idx + LW'(1);
      end
      if (last_acc)
        drain_cnt <= CW'(N);
      else if ((state == DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - CW'(1);
    end
  end

  // Shadow of the delay line: bit k qualifies the sample k+1 cycles old
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      vld_p <= '0;
    else if (start_go || abort_go || (state == CLEAR))
      vld_p <= '0;
    else
      vld_p <= {vld_p[N-1:0], acc};
  end

  assign d1_valid   = vld_p[0];
  assign dN_valid   = vld_p[N];
  assign pair_valid = vld_p[0] & vld_p[N];
  assign busy       = (state != IDLE);

endmodule
